// File: rtl/dds_pkg.sv
// Shared types and constants for the Doppler sweep sequencer.
// The SETTLE state exists only when DDS_SWEEP_SETTLE_EN is defined.
package dds_pkg;

    localparam int unsigned PHASE_INC_WIDTH_DEFAULT = 20;
    localparam int unsigned CA_INC                  = 1021613;
    localparam int unsigned INC_CALC_WIDTH          = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DWELL  = 2'd1,
        ST_STEP   = 2'd2
`ifdef DDS_SWEEP_SETTLE_EN
        ,
        ST_SETTLE = 2'd3
`endif
    } sweep_state_t;

    // Two's-complement add; callers truncate to their increment width, giving modulo wrap.
    function automatic logic [INC_CALC_WIDTH-1:0] inc_add(
        input logic [INC_CALC_WIDTH-1:0] a,
        input logic [INC_CALC_WIDTH-1:0] b
    );
        return a + b;
    endfunction

endpackage

// File: rtl/dds_doppler_sweep_if.sv
// Control/status bundle between acquisition control (master) and the sweep sequencer (slave).
// settle_active is present only when DDS_SWEEP_SETTLE_EN is defined.
interface dds_doppler_sweep_if
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_INC_WIDTH = PHASE_INC_WIDTH_DEFAULT,
    parameter int unsigned BIN_WIDTH       = 6,
    parameter int unsigned DWELL_WIDTH     = 16
);

    logic                       start;
    logic                       abort;
    logic [PHASE_INC_WIDTH-1:0] base_inc;
    logic [PHASE_INC_WIDTH-1:0] step_inc;
    logic [BIN_WIDTH-1:0]       num_bins;
    logic [DWELL_WIDTH-1:0]     dwell_cycles;
    logic [PHASE_INC_WIDTH-1:0] inc;
    logic [BIN_WIDTH-1:0]       bin_index;
    logic                       bin_done;
    logic                       busy;
    logic                       done;
`ifdef DDS_SWEEP_SETTLE_EN
    logic                       settle_active;

    modport master (
        output start, abort, base_inc, step_inc, num_bins, dwell_cycles,
        input  inc, bin_index, bin_done, busy, done, settle_active
    );

    modport slave (
        input  start, abort, base_inc, step_inc, num_bins, dwell_cycles,
        output inc, bin_index, bin_done, busy, done, settle_active
    );
`else
    modport master (
        output start, abort, base_inc, step_inc, num_bins, dwell_cycles,
        input  inc, bin_index, bin_done, busy, done
    );

    modport slave (
        input  start, abort, base_inc, step_inc, num_bins, dwell_cycles,
        output inc, bin_index, bin_done, busy, done
    );
`endif

endinterface

// File: rtl/dds_dwell_counter.sv
// Loadable down-counter timing one bin's dwell; last is high while the count sits at 1.
module dds_dwell_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             last
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign last = (count == WIDTH'(1));

endmodule

// File: rtl/dds_doppler_sweep.sv
// Doppler-bin sweep sequencer driving the DDS phase increment during acquisition.
// Optional per-bin settle interval compiled in with DDS_SWEEP_SETTLE_EN.
module dds_doppler_sweep
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_INC_WIDTH = PHASE_INC_WIDTH_DEFAULT,
    parameter int unsigned BIN_WIDTH       = 6,
    parameter int unsigned DWELL_WIDTH     = 16
`ifdef DDS_SWEEP_SETTLE_EN
    ,
    parameter int unsigned SETTLE_CYCLES   = 4
`endif
) (
    input  logic               clk,
    input  logic               reset,
    dds_doppler_sweep_if.slave bus
);

    localparam int unsigned PW = PHASE_INC_WIDTH;
    localparam int unsigned BW = BIN_WIDTH;
    localparam int unsigned DW = DWELL_WIDTH;

`ifdef DDS_SWEEP_SETTLE_EN
    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam sweep_state_t ST_BIN_ENTRY = ST_SETTLE;
    logic [SW-1:0] settle_cnt;
`else
    localparam sweep_state_t ST_BIN_ENTRY = ST_DWELL;
`endif

    sweep_state_t  state;
    logic [PW-1:0] inc_q;
    logic [PW-1:0] step_q;
    logic [BW-1:0] idx_q;
    logic [BW-1:0] last_bin_q;
    logic [DW-1:0] dwell_q;
    logic          busy_q;
    logic          done_q;

    logic          start_go;
    logic [DW-1:0] dwell_eff;
    logic          cnt_load;
    logic [DW-1:0] cnt_load_val;
    logic          cnt_en;
    logic          cnt_last;

    // A zero dwell would never expire, so it is promoted to one cycle.
    assign dwell_eff    = (bus.dwell_cycles == '0) ? DW'(1) : bus.dwell_cycles;
    assign start_go     = bus.start && !bus.abort && (state == ST_IDLE);
    assign cnt_load     = (start_go && (bus.num_bins != '0)) || (state == ST_STEP);
    assign cnt_load_val = (state == ST_IDLE) ? dwell_eff : dwell_q;
    assign cnt_en       = (state == ST_DWELL);

    dds_dwell_counter #(
        .WIDTH (DW)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            inc_q      <= '0;
            step_q     <= '0;
            idx_q      <= '0;
            last_bin_q <= '0;
            dwell_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DDS_SWEEP_SETTLE_EN
            settle_cnt <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        if (bus.num_bins != '0) begin
                            inc_q      <= bus.base_inc;
                            step_q     <= bus.step_inc;
                            last_bin_q <= bus.num_bins - BW'(1);
                            dwell_q    <= dwell_eff;
                            idx_q      <= '0;
                            busy_q     <= 1'b1;
                            state      <= ST_BIN_ENTRY;
`ifdef DDS_SWEEP_SETTLE_EN
                            settle_cnt <= SW'(SETTLE_CYCLES - 1);
`endif
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
`ifdef DDS_SWEEP_SETTLE_EN
                ST_SETTLE: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (settle_cnt == '0) begin
                        state <= ST_DWELL;
                    end else begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end
                end
`endif
                ST_DWELL: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (cnt_last) begin
                        if (idx_q == last_bin_q) begin
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state <= ST_STEP;
                        end
                    end
                end
                ST_STEP: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        inc_q <= PW'(inc_add(INC_CALC_WIDTH'(inc_q), INC_CALC_WIDTH'(step_q)));
                        idx_q <= idx_q + BW'(1);
                        state <= ST_BIN_ENTRY;
`ifdef DDS_SWEEP_SETTLE_EN
                        settle_cnt <= SW'(SETTLE_CYCLES - 1);
`endif
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // bin_done is gated by abort so an abort on the final dwell cycle retracts it.
    assign bus.inc       = inc_q;
    assign bus.bin_index = idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bin_done  = (state == ST_DWELL) && cnt_last && !bus.abort;
`ifdef DDS_SWEEP_SETTLE_EN
    assign bus.settle_active = (state == ST_SETTLE);
`endif

endmodule
